// File: rtl/regfile_dump_reader.sv
// Walks the register file read port from index 0 to NUM_REGS-1 after a start pulse
// and streams each word, tagged with its index, over a valid/ready interface.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;

    // An accepted word is replaced in the same cycle, so the stream has no bubbles.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    rd_addr_d = '0;
                end
            end
            LOAD: begin
                state_d     = SEND;
                out_data_d  = rd_data;
                out_index_d = rd_addr_q;
                out_valid_d = 1'b1;
                rd_addr_d   = rd_addr_q + ONE;
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    if (out_index_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        rd_addr_d   = '0;
                        state_d     = IDLE;
                    end else begin
                        out_data_d  = rd_data;
                        out_index_d = rd_addr_q;
                        rd_addr_d   = rd_addr_q + ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule
